// File: rtl/fifo_rd_packetizer.sv
// fifo_rd_packetizer: read-side consumer for async_fifo in the rclk domain.
// Pops show-ahead FIFO words into a 2-entry skid buffer and presents them on a
// valid/ready stream. o_last marks every PKT_LEN-th beat. o_beat numbers beats.
// Optional macro FIFO_RD_STATS_EN adds saturating pop and stall counters.
module fifo_rd_packetizer #(
    parameter  int DSIZE   = 32,
    parameter  int PKT_LEN = 16,
    localparam int CW      = $clog2(PKT_LEN) + 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [DSIZE-1:0] o_data,
    output logic             o_last,
    output logic [CW-1:0]    o_beat
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]      o_word_cnt,
    output logic [31:0]      o_stall_cnt
`endif
);

    typedef enum logic [1:0] {S0, S1, S2} state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [DSIZE-1:0] skid;
    logic             push;
    logic             pop;

    // The pop strobe depends only on registered occupancy, en and rempty, so
    // the downstream ready never reaches the FIFO combinationally.
    assign rinc    = en && !rempty && (state != S2) && !rrst;
    assign push    = rinc;
    assign o_valid = (state != S0);
    assign pop     = o_valid && o_ready;
    assign o_last  = o_valid && (o_beat == LAST_BEAT);

    // Occupancy register.
    always_ff @(posedge rclk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (rrst) state <= S0;
        else      state <= state_nxt;
    end

    // Next occupancy from push/pop.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        unique case (state)
            S0:      if (push) state_nxt = S1;
            S1: begin
                if (push && !pop)      state_nxt = S2;
                else if (pop && !push) state_nxt = S0;
            end
            S2:      if (pop) state_nxt = S1;
            default: state_nxt = S0;
        endcase
    end

    // Head entry: drives o_data, loaded from the FIFO or from the second entry.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            o_data <= '0;
        end else begin
            unique case (state)
                S0:      if (push) o_data <= rdata;
                S1:      if (push && pop) o_data <= rdata;
                S2:      if (pop) o_data <= skid;
                default: o_data <= o_data;
            endcase
        end
    end

    // Second entry: only loaded when a word arrives while the head is held.
    always_ff @(posedge rclk) begin
        // NOTE: pure data storage is not reset; occupancy alone says whether it
        // holds a live word, and leaving reset off keeps it a plain enable flop.
        if (state == S1 && push && !pop) skid <= rdata;
    end

    // Beat index of the head word; advances per delivered beat, wraps per packet.
    always_ff @(posedge rclk) begin
        if (rrst)     o_beat <= '0;
        else if (pop) o_beat <= (o_beat == LAST_BEAT) ? '0 : o_beat + 1'b1;
    end

`ifdef FIFO_RD_STATS_EN
    // Saturating counters of delivered words and back-pressured cycles.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            o_word_cnt  <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (pop && (o_word_cnt != '1))                    o_word_cnt  <= o_word_cnt + 32'd1;
            if (o_valid && !o_ready && (o_stall_cnt != '1))   o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_packetizer.sv
// Testbench for fifo_rd_packetizer. The async FIFO is modelled as a queue; a
// scoreboard queue holds words popped but not yet delivered, and the packet
// position is the count of delivered words modulo PKT_LEN.
module tb_fifo_rd_packetizer;

    localparam int DSIZE   = 32;
    localparam int PKT_LEN = 16;
    localparam int CW      = $clog2(PKT_LEN) + 1;

    logic             clk = 1'b0;
    logic             rrst;
    logic             en;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             o_valid;
    logic             o_ready;
    logic [DSIZE-1:0] o_data;
    logic             o_last;
    logic [CW-1:0]    o_beat;
`ifdef FIFO_RD_STATS_EN
    logic [31:0]      o_word_cnt;
    logic [31:0]      o_stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_packetizer #(.DSIZE(DSIZE), .PKT_LEN(PKT_LEN)) dut (
        .rclk    (clk),
        .rrst    (rrst),
        .en      (en),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_beat  (o_beat)
`ifdef FIFO_RD_STATS_EN
        ,
        .o_word_cnt  (o_word_cnt),
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] exp_q[$];
    int beat_idx;
    int vectors;
    int miscompares;
    int dut_pulses;
    int dut_valid_cycles;
    int dut_acc;
    int dut_last;
    longint word_cnt_m;
    longint stall_cnt_m;

    task automatic refresh_fifo();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? DSIZE'($urandom) : fifo_q[0];
    endtask

    task automatic fifo_write(input logic [DSIZE-1:0] val);
        fifo_q.push_back(val);
        refresh_fifo();
    endtask

    task automatic model_reset();
        exp_q.delete();
        beat_idx    = 0;
        word_cnt_m  = 0;
        stall_cnt_m = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, then
    // let the rising edge happen and refresh the FIFO's read port.
    task automatic tick();
        logic             exp_rinc;
        logic             exp_valid;
        logic [DSIZE-1:0] tmp;
        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        exp_rinc  = en && (fifo_q.size() != 0) && (exp_q.size() < 2) && !rrst;
        vectors++;
        if (rinc !== exp_rinc) begin
            miscompares++;
            $display("FAIL rinc t=%0t got %b expected %b", $time, rinc, exp_rinc);
        end
        vectors++;
        if (o_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL o_valid t=%0t got %b expected %b", $time, o_valid, exp_valid);
        end
        if (exp_valid) begin
            vectors++;
            if (o_data !== exp_q[0]) begin
                miscompares++;
                $display("FAIL o_data t=%0t got %h expected %h", $time, o_data, exp_q[0]);
            end
            vectors++;
            if (o_beat !== CW'(beat_idx)) begin
                miscompares++;
                $display("FAIL o_beat t=%0t got %0d expected %0d", $time, o_beat, beat_idx);
            end
            vectors++;
            if (o_last !== (beat_idx == PKT_LEN - 1)) begin
                miscompares++;
                $display("FAIL o_last t=%0t got %b expected %b", $time, o_last, beat_idx == PKT_LEN - 1);
            end
        end else begin
            vectors++;
            if (o_last !== 1'b0) begin
                miscompares++;
                $display("FAIL o_last_idle t=%0t got %b expected 0", $time, o_last);
            end
        end
`ifdef FIFO_RD_STATS_EN
        vectors++;
        if (o_word_cnt !== 32'(word_cnt_m)) begin
            miscompares++;
            $display("FAIL o_word_cnt t=%0t got %0d expected %0d", $time, o_word_cnt, word_cnt_m);
        end
        vectors++;
        if (o_stall_cnt !== 32'(stall_cnt_m)) begin
            miscompares++;
            $display("FAIL o_stall_cnt t=%0t got %0d expected %0d", $time, o_stall_cnt, stall_cnt_m);
        end
`endif
        if (rinc === 1'b1) dut_pulses++;
        if (o_valid === 1'b1) dut_valid_cycles++;
        if (o_valid === 1'b1 && o_ready) dut_acc++;
        if (o_last === 1'b1 && o_ready) dut_last++;
        if (rrst) begin
            model_reset();
        end else begin
            if (exp_valid && !o_ready) stall_cnt_m++;
            if (exp_valid && o_ready) begin
                tmp      = exp_q.pop_front();
                beat_idx = (beat_idx + 1) % PKT_LEN;
                word_cnt_m++;
            end
            if (exp_rinc) exp_q.push_back(fifo_q.pop_front());
        end
        @(posedge clk);
        #1;
        refresh_fifo();
    endtask

    task automatic pulse_reset();
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_beat !== '0 || o_data !== '0 || rinc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values valid=%b last=%b beat=%0d data=%h rinc=%b expected all zero",
                     o_valid, o_last, o_beat, o_data, rinc);
        end
        en      = 1'b1;
        o_ready = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_single();
        int p0;
        int v0;
        pulse_reset();
        p0 = dut_pulses;
        v0 = dut_valid_cycles;
        fifo_write(DSIZE'('hA));
        repeat (6) tick();
        vectors++;
        if (dut_pulses - p0 != 1) begin
            miscompares++;
            $display("FAIL single_pulses got %0d expected 1", dut_pulses - p0);
        end
        vectors++;
        if (dut_valid_cycles - v0 != 1) begin
            miscompares++;
            $display("FAIL single_valid_cycles got %0d expected 1", dut_valid_cycles - v0);
        end
    endtask

    task automatic test_stream();
        int a0;
        int l0;
        pulse_reset();
        a0 = dut_acc;
        l0 = dut_last;
        for (int i = 0; i < 32; i++) fifo_write(DSIZE'(i));
        repeat (40) tick();
        vectors++;
        if (dut_acc - a0 != 32) begin
            miscompares++;
            $display("FAIL stream_beats got %0d expected 32", dut_acc - a0);
        end
        vectors++;
        if (dut_last - l0 != 2) begin
            miscompares++;
            $display("FAIL stream_lasts got %0d expected 2", dut_last - l0);
        end
    endtask

    task automatic test_back_pressure();
        int p0;
        int a0;
        pulse_reset();
        o_ready = 1'b0;
        p0 = dut_pulses;
        a0 = dut_acc;
        for (int i = 0; i < 10; i++) fifo_write(DSIZE'(i));
        repeat (10) tick();
        vectors++;
        if (dut_pulses - p0 != 2) begin
            miscompares++;
            $display("FAIL bp_pops got %0d expected 2", dut_pulses - p0);
        end
        o_ready = 1'b1;
        repeat (15) tick();
        vectors++;
        if (dut_acc - a0 != 10) begin
            miscompares++;
            $display("FAIL bp_delivered got %0d expected 10", dut_acc - a0);
        end
    endtask

    task automatic test_enable();
        int p0;
        int a0;
        int n;
        pulse_reset();
        en      = 1'b1;
        o_ready = 1'b1;
        p0 = dut_pulses;
        a0 = dut_acc;
        for (int i = 0; i < 8; i++) fifo_write(DSIZE'(i));
        n = 0;
        while (dut_pulses - p0 < 3 && n < 20) begin
            tick();
            n++;
        end
        en = 1'b0;
        repeat (6) tick();
        vectors++;
        if (dut_pulses - p0 != 3) begin
            miscompares++;
            $display("FAIL en_pops got %0d expected 3", dut_pulses - p0);
        end
        vectors++;
        if (dut_acc - a0 != 3) begin
            miscompares++;
            $display("FAIL en_delivered got %0d expected 3", dut_acc - a0);
        end
        en = 1'b1;
        repeat (12) tick();
        vectors++;
        if (dut_acc - a0 != 8) begin
            miscompares++;
            $display("FAIL en_resume got %0d expected 8", dut_acc - a0);
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        en      = 1'b1;
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(DSIZE'(32'h100 + i));
        repeat (4) tick();
        pulse_reset();
        vectors++;
        if (o_valid !== 1'b0 || o_beat !== '0) begin
            miscompares++;
            $display("FAIL mid_reset valid=%b beat=%0d expected 0 0", o_valid, o_beat);
        end
`ifdef FIFO_RD_STATS_EN
        vectors++;
        if (o_word_cnt !== 32'd0 || o_stall_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL stats_reset words=%0d stalls=%0d expected 0 0", o_word_cnt, o_stall_cnt);
        end
`endif
        repeat (6) tick();
`ifdef FIFO_RD_STATS_EN
        vectors++;
        if (o_stall_cnt !== 32'd5) begin
            miscompares++;
            $display("FAIL stats_stall got %0d expected 5", o_stall_cnt);
        end
`endif
        o_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            o_ready = ($urandom_range(0, 9) < 7);
            rrst    = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 1) == 1) fifo_write(DSIZE'($urandom));
            tick();
        end
        rrst    = 1'b0;
        en      = 1'b1;
        o_ready = 1'b1;
        repeat (fifo_q.size() + 10) tick();
        vectors++;
        if (exp_q.size() != 0 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL random_drain left=%0d valid=%b expected 0 0", exp_q.size(), o_valid);
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        dut_pulses       = 0;
        dut_valid_cycles = 0;
        dut_acc          = 0;
        dut_last         = 0;
        rrst    = 1'b1;
        en      = 1'b0;
        o_ready = 1'b0;
        model_reset();
        refresh_fifo();
        repeat (2) @(posedge clk);
        #1;
        rrst = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_back_pressure();
        test_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packetizer.md
Name: fifo_rd_packetizer

Overview:
- Read-side consumer that sits directly downstream of async_fifo in the rclk domain.
- Pops words from the FIFO's show-ahead read port (rdata is valid whenever rempty is low; rinc pops) and re-presents them on a valid/ready stream.
- Buffers words in a 2-entry skid buffer, so o_ready never combinationally reaches rinc.
- Marks packet boundaries with o_last every PKT_LEN beats.

Parameters:
- DSIZE, 32, data width; must match the async_fifo DSIZE.
- PKT_LEN, 16, beats per packet, legal range 1..65535.
- CW, $clog2(PKT_LEN)+1 (derived localparam), beat counter width.

Ports:
- rclk  in  1  read-domain clock; same net as async_fifo rclk.
- rrst  in  1  synchronous, active-high reset.
- en  in  1  pop enable; when low, no new pops, but buffered words still drain.
- rempty  in  1  from async_fifo; high means no word available.
- rdata  in  DSIZE  from async_fifo; valid while rempty is low.
- rinc  out  1  to async_fifo; pop strobe.
- o_valid  out  1  stream valid.
- o_ready  in  1  stream ready from the consumer.
- o_data  out  DSIZE  stream data.
- o_last  out  1  high on the final beat of each PKT_LEN-beat packet.
- o_beat  out  CW  index of the current beat within its packet, 0..PKT_LEN-1.

Behaviour:
- All state updates on the rising edge of rclk. rrst is sampled only on that edge.
- Reset values: rinc=0, o_valid=0, o_data=0, o_last=0, o_beat=0, buffer count=0.
- Reset mid-operation discards buffered words and restarts the packet at beat 0. FIFO contents are not affected.
- Buffer state machine, keyed by occupancy:
  - S0 (empty), S1 (one entry), S2 (two entries).
  - push = rinc; pop = o_valid && o_ready.
  - S0: push -> S1.
  - S1: push and no pop -> S2; pop and no push -> S0; both or neither -> S1.
  - S2: pop -> S1; push is impossible in S2.
- rinc is combinational: rinc = en && !rempty && (state != S2) && !rrst. It depends only on registered state, en and rempty, never on o_ready.
- Push timing: when rinc is high, rdata is captured in the same cycle. The word appears on o_data at the next edge (latency 1 cycle from pop to o_valid).
- Ordering: strict FIFO. The head entry always drives o_data. On a pop in S2, the second entry moves to head in the same edge.
- o_valid = (state != S0), registered. o_data and o_last must be held stable while o_valid && !o_ready.
- Throughput: sustained 1 beat/cycle when rempty=0, en=1 and o_ready=1, steady in S1.
- Beat counter:
  - Advances only on a pop. Wraps from PKT_LEN-1 to 0.
  - o_beat reflects the beat number of the head word.
  - o_last = (o_beat == PKT_LEN-1) && o_valid.
  - PKT_LEN=1: o_last is high on every valid beat.
- en deassertion: takes effect on the same cycle's rinc. Already-buffered words (up to 2) still complete.
- rempty rising while words are buffered: the buffer drains normally; o_valid falls once it is empty.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- When defined, adds two outputs:
  - o_word_cnt (32 bits): counts pops.
  - o_stall_cnt (32 bits): counts cycles with o_valid && !o_ready.
  - Both reset to 0 on rrst and saturate at 32'hFFFFFFFF without wrapping.
- When not defined, these ports and their logic do not exist, and all other behaviour is identical.

Test Plan:
- Idle after reset, rempty=1 -> rinc=0, o_valid=0, o_last=0, o_beat=0 for 20 cycles.
- Write 0xA into async_fifo, o_ready=1 -> exactly one rinc pulse; o_data=0xA with o_valid for one cycle; o_beat=0; o_last=0 (PKT_LEN=16).
- Write 0..31, o_ready=1 -> 32 beats in order 0..31; o_last high on values 15 and 31; o_beat wraps 15->0; rinc never high while buffer is in S2.
- Write 0..9, hold o_ready=0 -> exactly 2 pops, o_data=0 held stable, rinc=0 thereafter. Then o_ready=1 -> 0..9 delivered without loss or duplication.
- Write 0..7, deassert en after the 3rd pop -> words 0..2 delivered, no further pops. Reassert en -> 3..7 follow.
- Assert rrst for one cycle with 2 words buffered -> o_valid=0 and o_beat=0 the next cycle; the next word popped from the FIFO is the first one not yet popped. With FIFO_RD_STATS_EN: o_word_cnt=0 and o_stall_cnt=0 after reset; 5 stall cycles -> o_stall_cnt=5.
